// File: rtl/vec_pkg.sv
// Shared encodings, instruction payload and sizing helpers for the vector sequencer.
package vec_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned NUM_VREGS = 32;
  localparam int unsigned RIDX_W    = 5;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_MV  = 3'b101
  } vop_e;

  typedef enum logic [1:0] {
    SEW_8  = 2'd0,
    SEW_16 = 2'd1,
    SEW_32 = 2'd2
  } sew_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  // Instruction fields held for the lifetime of one accepted instruction.
  typedef struct packed {
    vop_e              op;
    sew_e              sew;
    logic [RIDX_W-1:0] vd;
  } instr_t;

  function automatic logic [XLEN-1:0] sew_mask(sew_e sew);
    case (sew)
      SEW_8:   sew_mask = 32'h0000_00FF;
      SEW_16:  sew_mask = 32'h0000_FFFF;
      default: sew_mask = 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic int unsigned vlmax(int unsigned vlen, sew_e sew);
    return vlen >> (32'(sew) + 32'd3);
  endfunction

endpackage

// File: rtl/vec_elem_alu.sv
// Combinational single-element integer op; result truncated to the element width.
module vec_elem_alu
  import vec_pkg::*;
(
  input  vop_e            op,
  input  sew_e            sew,
  input  logic [XLEN-1:0] vs2_el,
  input  logic [XLEN-1:0] vs1_el,
  output logic [XLEN-1:0] res_c
);

  logic [XLEN-1:0] raw;

  always_comb begin
    raw = '0;
    case (op)
      OP_ADD:  raw = vs2_el + vs1_el;
      OP_SUB:  raw = vs2_el - vs1_el;
      OP_AND:  raw = vs2_el & vs1_el;
      OP_OR:   raw = vs2_el | vs1_el;
      OP_XOR:  raw = vs2_el ^ vs1_el;
      OP_MV:   raw = vs1_el;
      default: raw = '0;
    endcase
    // Low SEW bits of a 32-bit wrap equal the SEW-wide wrap.
    res_c = raw & sew_mask(sew);
  end

endmodule

// File: rtl/vec_elem_sequencer.sv
// Element-serial vector-vector integer stage: snapshot sources, one element per cycle, one vd write.
// Optional VEC_MASK_EN: honour vm=0 by gating each element with its v0 bit.
module vec_elem_sequencer
  import vec_pkg::*;
#(
  parameter int unsigned VLEN = 128
) (
  input  logic                   SYS_clk,
  input  logic                   SYS_reset_n,
  input  logic                   start,
  input  logic [2:0]             op,
  input  logic [RIDX_W-1:0]      vd,
  input  logic [RIDX_W-1:0]      vs1,
  input  logic [RIDX_W-1:0]      vs2,
  input  logic                   vm,
  input  logic                   flush,
  input  logic [VLEN*32-1:0]     v_regs,
  input  logic [XLEN-1:0]        vl,
  input  logic [XLEN-1:0]        vstart,
  input  logic [2:0]             vsew,
  input  logic [2:0]             vlmul,
  input  logic                   vill,
  output logic                   busy,
  output logic                   done,
  output logic                   illegal,
  output logic                   aborted,
  output logic                   wr_en,
  output logic [RIDX_W-1:0]      wr_addr,
  output logic [VLEN-1:0]        wr_data,
  output logic [XLEN-1:0]        vstart_out
);

  localparam int unsigned ELEM_MAX = VLEN / 8;
  localparam int unsigned IDX_W    = $clog2(ELEM_MAX + 1);
  localparam int unsigned SH_W     = $clog2(VLEN);

  state_e             state_q, state_d;
  instr_t             ins_q, ins_d;
  logic [IDX_W-1:0]   idx_q, idx_d, end_q, end_d;
  logic [VLEN-1:0]    vs1_q, vs1_d, vs2_q, vs2_d, buf_q, buf_d;
  logic               abort_q, abort_d;
  logic               pend_q, pend_d, pend_ill_q, pend_ill_d;
  logic [XLEN-1:0]    pend_vso_q, pend_vso_d;

  logic               busy_d, done_d, illegal_d, aborted_d, wr_en_d;
  logic [RIDX_W-1:0]  wr_addr_d;
  logic [VLEN-1:0]    wr_data_d;
  logic [XLEN-1:0]    vstart_out_d;

  logic               bad_c, active_c;
  logic [XLEN-1:0]    vlmax_c, end_c;
  logic [SH_W-1:0]    sh_c;
  logic [XLEN-1:0]    vs1_el_c, vs2_el_c, res_c;
  logic [VLEN-1:0]    merged_c;
  logic [VLEN-1:0]    regs_c [NUM_VREGS];

  for (genvar r = 0; r < NUM_VREGS; r++) begin : g_regs
    assign regs_c[r] = v_regs[r*VLEN +: VLEN];
  end

  assign bad_c   = vill || (vsew > 3'd2) || (vlmul != 3'd0) || (op[2:1] == 2'b11);
  assign vlmax_c = XLEN'(vlmax(VLEN, sew_e'(vsew[1:0])));
  assign end_c   = (vl < vlmax_c) ? vl : vlmax_c;

  // Bit offset of the current element inside a register.
  assign sh_c     = SH_W'(XLEN'(idx_q) << (XLEN'(ins_q.sew) + XLEN'(3)));
  assign vs1_el_c = XLEN'(vs1_q >> sh_c);
  assign vs2_el_c = XLEN'(vs2_q >> sh_c);
  assign merged_c = (buf_q & ~(VLEN'(sew_mask(ins_q.sew)) << sh_c)) | (VLEN'(res_c) << sh_c);

  vec_elem_alu u_alu (
    .op     (ins_q.op),
    .sew    (ins_q.sew),
    .vs2_el (vs2_el_c),
    .vs1_el (vs1_el_c),
    .res_c  (res_c)
  );

`ifdef VEC_MASK_EN
  logic                vm_q, vm_d;
  logic [ELEM_MAX-1:0] v0_q, v0_d, v0_sh_c;
  assign v0_sh_c  = v0_q >> idx_q;
  assign active_c = vm_q | v0_sh_c[0];
`else
  logic unused_vm_c;
  assign unused_vm_c = vm;
  assign active_c    = 1'b1;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    ins_d        = ins_q;
    idx_d        = idx_q;
    end_d        = end_q;
    vs1_d        = vs1_q;
    vs2_d        = vs2_q;
    buf_d        = buf_q;
    abort_d      = abort_q;
    pend_d       = 1'b0;
    pend_ill_d   = pend_ill_q;
    pend_vso_d   = pend_vso_q;
    done_d       = 1'b0;
    illegal_d    = 1'b0;
    aborted_d    = 1'b0;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr;
    wr_data_d    = wr_data;
    vstart_out_d = vstart_out;
`ifdef VEC_MASK_EN
    vm_d         = vm_q;
    v0_d         = v0_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (pend_q) begin
          done_d       = 1'b1;
          illegal_d    = pend_ill_q;
          vstart_out_d = pend_vso_q;
        end
        if (start) begin
          if (bad_c) begin
            pend_d     = 1'b1;
            pend_ill_d = 1'b1;
            pend_vso_d = vstart;
          end else if (vstart >= end_c) begin
            pend_d     = 1'b1;
            pend_ill_d = 1'b0;
            pend_vso_d = '0;
          end else begin
            state_d   = ST_RUN;
            ins_d.op  = vop_e'(op);
            ins_d.sew = sew_e'(vsew[1:0]);
            ins_d.vd  = vd;
            idx_d     = IDX_W'(vstart);
            end_d     = IDX_W'(end_c);
            abort_d   = 1'b0;
            vs1_d     = regs_c[vs1];
            vs2_d     = regs_c[vs2];
            buf_d     = regs_c[vd];
`ifdef VEC_MASK_EN
            vm_d      = vm;
            v0_d      = regs_c[0][ELEM_MAX-1:0];
`endif
          end
        end
      end
      ST_RUN: begin
        if (flush) begin
          abort_d = 1'b1;
          state_d = ST_WRITE;
        end else begin
          if (active_c) buf_d = merged_c;
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == end_q - IDX_W'(1)) state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        wr_en_d      = 1'b1;
        wr_addr_d    = ins_q.vd;
        wr_data_d    = buf_q;
        vstart_out_d = abort_q ? XLEN'(idx_q) : '0;
        done_d       = 1'b1;
        aborted_d    = abort_q;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
    if (!SYS_reset_n) begin
      state_q    <= ST_IDLE;
      ins_q      <= '0;
      idx_q      <= '0;
      end_q      <= '0;
      vs1_q      <= '0;
      vs2_q      <= '0;
      buf_q      <= '0;
      abort_q    <= 1'b0;
      pend_q     <= 1'b0;
      pend_ill_q <= 1'b0;
      pend_vso_q <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      illegal    <= 1'b0;
      aborted    <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      vstart_out <= '0;
`ifdef VEC_MASK_EN
      vm_q       <= 1'b0;
      v0_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ins_q      <= ins_d;
      idx_q      <= idx_d;
      end_q      <= end_d;
      vs1_q      <= vs1_d;
      vs2_q      <= vs2_d;
      buf_q      <= buf_d;
      abort_q    <= abort_d;
      pend_q     <= pend_d;
      pend_ill_q <= pend_ill_d;
      pend_vso_q <= pend_vso_d;
      busy       <= busy_d;
      done       <= done_d;
      illegal    <= illegal_d;
      aborted    <= aborted_d;
      wr_en      <= wr_en_d;
      wr_addr    <= wr_addr_d;
      wr_data    <= wr_data_d;
      vstart_out <= vstart_out_d;
`ifdef VEC_MASK_EN
      vm_q       <= vm_d;
      v0_q       <= v0_d;
`endif
    end
  end

endmodule

// File: tb/tb_vec_elem_sequencer.sv
// Randomized self-checking bench for vec_elem_sequencer against an element-array reference model.
`timescale 1ns/1ps
module tb_vec_elem_sequencer;

  localparam int unsigned VLEN = 128;

  logic              SYS_clk = 1'b0;
  logic              SYS_reset_n = 1'b0;
  logic              start, vm, flush, vill;
  logic [2:0]        op, vsew, vlmul;
  logic [4:0]        vd, vs1, vs2;
  logic [VLEN*32-1:0] v_regs;
  logic [31:0]       vl, vstart;
  logic              busy, done, illegal, aborted, wr_en;
  logic [4:0]        wr_addr;
  logic [VLEN-1:0]   wr_data;
  logic [31:0]       vstart_out;

  logic [VLEN-1:0]   rf [32];
  int                n_vec = 0;
  int                n_err = 0;

  for (genvar r = 0; r < 32; r++) begin : g_pack
    assign v_regs[r*VLEN +: VLEN] = rf[r];
  end

  vec_elem_sequencer #(.VLEN(VLEN)) dut (
    .SYS_clk(SYS_clk), .SYS_reset_n(SYS_reset_n), .start(start), .op(op),
    .vd(vd), .vs1(vs1), .vs2(vs2), .vm(vm), .flush(flush), .v_regs(v_regs),
    .vl(vl), .vstart(vstart), .vsew(vsew), .vlmul(vlmul), .vill(vill),
    .busy(busy), .done(done), .illegal(illegal), .aborted(aborted),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .vstart_out(vstart_out)
  );

  always #5 SYS_clk = ~SYS_clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [VLEN-1:0] got, input logic [VLEN-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---- reference model: registers viewed as arrays of SEW-bit elements ----
  function automatic logic [31:0] get_el(input logic [VLEN-1:0] r, input int i, input int sb);
    logic [31:0] v = '0;
    for (int j = 0; j < sb; j++) v[j] = r[i*sb + j];
    return v;
  endfunction

  function automatic logic [VLEN-1:0] set_el(input logic [VLEN-1:0] r, input int i, input int sb,
                                             input logic [31:0] v);
    logic [VLEN-1:0] o = r;
    for (int j = 0; j < sb; j++) o[i*sb + j] = v[j];
    return o;
  endfunction

  function automatic logic [31:0] alu_ref(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b, input int sb);
    longint unsigned m = 64'd1 << sb;
    longint unsigned x = a;
    longint unsigned y = b;
    longint unsigned z;
    case (o)
      3'd0:    z = (x + y) % m;
      3'd1:    z = (x + m - y) % m;
      3'd2:    z = x & y;
      3'd3:    z = x | y;
      3'd4:    z = x ^ y;
      default: z = y;
    endcase
    return 32'(z);
  endfunction

  function automatic logic [VLEN-1:0] model_data(input logic [2:0] o, input logic [4:0] d,
      input logic [4:0] s1, input logic [4:0] s2, input logic m, input int first, input int last,
      input int sb);
    logic [VLEN-1:0] r = rf[d];
    for (int i = first; i < last; i++) begin
      bit act = 1'b1;
`ifdef VEC_MASK_EN
      if (!m) act = rf[0][i];
`else
      act = act | m;
`endif
      if (act) r = set_el(r, i, sb, alu_ref(o, get_el(rf[s2], i, sb), get_el(rf[s1], i, sb), sb));
    end
    return r;
  endfunction

  // Issue one instruction, optionally flush in RUN cycle flush_at (1-based), check the completion.
  task automatic run_instr(input string tag, input logic [2:0] op_i, input logic [4:0] vd_i,
      input logic [4:0] vs1_i, input logic [4:0] vs2_i, input logic vm_i, input logic [31:0] vl_i,
      input logic [31:0] vstart_i, input logic [2:0] vsew_i, input logic [2:0] vlmul_i,
      input logic vill_i, input int flush_at, input bit poke);
    bit ill, empty, exp_wr, exp_ab;
    int sb, emax, e, n, lat, c;
    logic [31:0] exp_vso;
    logic [VLEN-1:0] exp_data;
    ill = vill_i || (vsew_i > 3'd2) || (vlmul_i != 3'd0) || (op_i > 3'd5);
    sb = ill ? 8 : (8 << vsew_i);
    emax = VLEN / sb;
    e = (vl_i < 32'(emax)) ? int'(vl_i) : emax;
    empty = !ill && (longint'(vstart_i) >= longint'(e));
    exp_wr = 1'b0; exp_ab = 1'b0; exp_data = '0;
    if (ill) begin
      lat = 1; exp_vso = vstart_i;
    end else if (empty) begin
      lat = 1; exp_vso = '0;
    end else begin
      n = e - int'(vstart_i);
      exp_wr = 1'b1;
      if (flush_at >= 1 && flush_at <= n) begin
        lat = flush_at + 1; exp_ab = 1'b1; exp_vso = vstart_i + 32'(flush_at - 1);
        exp_data = model_data(op_i, vd_i, vs1_i, vs2_i, vm_i, int'(vstart_i),
                              int'(vstart_i) + flush_at - 1, sb);
      end else begin
        lat = n + 1; exp_vso = '0;
        exp_data = model_data(op_i, vd_i, vs1_i, vs2_i, vm_i, int'(vstart_i), e, sb);
      end
    end

    @(negedge SYS_clk);
    op = op_i; vd = vd_i; vs1 = vs1_i; vs2 = vs2_i; vm = vm_i; vl = vl_i; vstart = vstart_i;
    vsew = vsew_i; vlmul = vlmul_i; vill = vill_i; start = 1'b1;
    @(negedge SYS_clk);
    start = 1'b0;
    c = 0;
    chk({tag, ".busy"}, VLEN'(busy), VLEN'(!(ill || empty)));
    forever begin
      if (done || c >= 200) break;
      if (wr_en) chk({tag, ".stray_wr"}, VLEN'(wr_en), '0);
      flush = (flush_at > 0 && c == flush_at - 1);
      start = (poke && c == 1 && lat >= 2);
      if (start) op = op_i + 3'd1;
      @(negedge SYS_clk);
      c++;
    end
    flush = 1'b0; start = 1'b0;
    chk({tag, ".lat"}, VLEN'(c), VLEN'(lat));
    chk({tag, ".illegal"}, VLEN'(illegal), VLEN'(ill));
    chk({tag, ".aborted"}, VLEN'(aborted), VLEN'(exp_ab));
    chk({tag, ".wr_en"}, VLEN'(wr_en), VLEN'(exp_wr));
    chk({tag, ".vstart_out"}, VLEN'(vstart_out), VLEN'(exp_vso));
    if (exp_wr) begin
      chk({tag, ".wr_addr"}, VLEN'(wr_addr), VLEN'(vd_i));
      chk({tag, ".wr_data"}, wr_data, exp_data);
      rf[vd_i] = exp_data;
    end
    @(negedge SYS_clk);
    chk({tag, ".pulse"}, VLEN'({done, wr_en, busy}), '0);
  endtask

  initial begin
    logic [VLEN-1:0] full, old;
    bit seen;
    start = 0; op = 0; vd = 0; vs1 = 0; vs2 = 0; vm = 1; flush = 0;
    vl = 0; vstart = 0; vsew = 0; vlmul = 0; vill = 0;
    for (int r = 0; r < 32; r++)
      rf[r] = {$urandom(), $urandom(), $urandom(), $urandom()};

    repeat (3) @(negedge SYS_clk);
    chk("rst.busy", VLEN'(busy), '0);
    chk("rst.done", VLEN'(done), '0);
    chk("rst.flags", VLEN'({illegal, aborted, wr_en}), '0);
    chk("rst.wr_addr", VLEN'(wr_addr), '0);
    chk("rst.wr_data", wr_data, '0);
    chk("rst.vstart_out", VLEN'(vstart_out), '0);
    SYS_reset_n = 1'b1;
    @(negedge SYS_clk);

    // SEW=32 add with a wrapping element
    rf[1] = {32'd1, 32'd1, 32'd1, 32'd1};
    rf[2] = {32'd4, 32'd3, 32'd2, 32'hFFFF_FFFF};
    run_instr("add32", 3'd0, 5'd3, 5'd1, 5'd2, 1'b1, 32'd4, 32'd0, 3'd2, 3'd0, 1'b0, 0, 1'b1);
    chk("add32.const", wr_data, {32'd5, 32'd4, 32'd3, 32'd0});

    // SEW=8 sub, vl clamped to 16, 0x00-0x01 wraps
    rf[4][7:0] = 8'h00;
    rf[5][7:0] = 8'h01;
    run_instr("sub8", 3'd1, 5'd6, 5'd5, 5'd4, 1'b1, 32'd20, 32'd0, 3'd0, 3'd0, 1'b0, 0, 1'b0);
    chk("sub8.wrap", VLEN'(wr_data[7:0]), VLEN'(8'hFF));

    run_instr("xor_vs2", 3'd4, 5'd7, 5'd8, 5'd9, 1'b1, 32'd3, 32'd2, 3'd2, 3'd0, 1'b0, 0, 1'b0);

    // Flush then resume from the reported vstart
    full = model_data(3'd0, 5'd10, 5'd11, 5'd12, 1'b1, 0, 8, 16);
    run_instr("flush", 3'd0, 5'd10, 5'd11, 5'd12, 1'b1, 32'd8, 32'd0, 3'd1, 3'd0, 1'b0, 3, 1'b0);
    run_instr("resume", 3'd0, 5'd10, 5'd11, 5'd12, 1'b1, 32'd8, 32'd2, 3'd1, 3'd0, 1'b0, 0, 1'b0);
    chk("resume.full", wr_data, full);
    run_instr("flush_wr", 3'd2, 5'd16, 5'd17, 5'd18, 1'b1, 32'd4, 32'd0, 3'd2, 3'd0, 1'b0, 5, 1'b0);

    run_instr("vill", 3'd0, 5'd3, 5'd1, 5'd2, 1'b1, 32'd4, 32'd1, 3'd2, 3'd0, 1'b1, 0, 1'b0);
    run_instr("lmul", 3'd0, 5'd3, 5'd1, 5'd2, 1'b1, 32'd4, 32'd0, 3'd2, 3'd1, 1'b0, 0, 1'b0);
    run_instr("op110", 3'd6, 5'd3, 5'd1, 5'd2, 1'b1, 32'd4, 32'd0, 3'd2, 3'd0, 1'b0, 0, 1'b0);
    run_instr("sew3", 3'd0, 5'd3, 5'd1, 5'd2, 1'b1, 32'd4, 32'd0, 3'd3, 3'd0, 1'b0, 0, 1'b0);
    run_instr("vl0", 3'd0, 5'd3, 5'd1, 5'd2, 1'b1, 32'd0, 32'd0, 3'd0, 3'd0, 1'b0, 0, 1'b0);
    run_instr("vs_ge", 3'd0, 5'd3, 5'd1, 5'd2, 1'b1, 32'd3, 32'd5, 3'd0, 3'd0, 1'b0, 0, 1'b0);
    run_instr("alias", 3'd0, 5'd20, 5'd20, 5'd20, 1'b1, 32'd8, 32'd0, 3'd1, 3'd0, 1'b0, 0, 1'b0);

`ifdef VEC_MASK_EN
    rf[0] = 128'h5;
    old = rf[13];
    run_instr("mask", 3'd0, 5'd13, 5'd14, 5'd15, 1'b0, 32'd4, 32'd0, 3'd2, 3'd0, 1'b0, 0, 1'b0);
    chk("mask.el1", VLEN'(wr_data[63:32]), VLEN'(old[63:32]));
    chk("mask.el3", VLEN'(wr_data[127:96]), VLEN'(old[127:96]));
`endif

    for (int t = 0; t < 80; t++) begin
      logic [2:0] r_op, r_sew, r_lmul;
      logic r_vill;
      int r_fl;
      r_op   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
      r_sew  = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      r_lmul = ($urandom_range(0, 11) == 0) ? 3'd1 : 3'd0;
      r_vill = ($urandom_range(0, 14) == 0);
      r_fl   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 18) : 0;
      run_instr("rand", r_op, 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom),
                32'($urandom_range(0, 40)), 32'($urandom_range(0, 18)), r_sew, r_lmul, r_vill,
                r_fl, ($urandom_range(0, 2) == 0));
    end

    // Reset in the middle of RUN: everything clears, no write afterwards
    @(negedge SYS_clk);
    op = 3'd0; vd = 5'd21; vs1 = 5'd22; vs2 = 5'd23; vm = 1'b1; vl = 32'd16; vstart = 32'd0;
    vsew = 3'd0; vlmul = 3'd0; vill = 1'b0; start = 1'b1;
    @(negedge SYS_clk);
    start = 1'b0;
    repeat (3) @(negedge SYS_clk);
    chk("mid.busy_before", VLEN'(busy), VLEN'(1'b1));
    SYS_reset_n = 1'b0;
    #1;
    chk("mid.busy", VLEN'(busy), '0);
    chk("mid.flags", VLEN'({done, illegal, aborted, wr_en}), '0);
    chk("mid.wr_data", wr_data, '0);
    chk("mid.vstart_out", VLEN'(vstart_out), '0);
    repeat (2) @(negedge SYS_clk);
    SYS_reset_n = 1'b1;
    seen = 1'b0;
    repeat (24) begin
      @(negedge SYS_clk);
      seen = seen | wr_en | done | busy;
    end
    chk("mid.no_write", VLEN'(seen), '0);

    run_instr("post_rst", 3'd3, 5'd24, 5'd25, 5'd26, 1'b1, 32'd8, 32'd1, 3'd1, 3'd0, 1'b0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vec_elem_sequencer.md
# vec_elem_sequencer

Element-serial vector execution stage that sits directly upstream of the vector register file. It accepts one vector-vector integer instruction and reads source registers from the register file's flattened `v_regs` bus. It then processes elements `vstart..vl-1` one per cycle and returns a single destination-register write plus the updated `vstart`, which the merge logic turns into `new_v_regs` / `new_vstart`. Only LMUL=1 is supported; SEW is 8, 16 or 32.

## Interface
- `VLEN`, default 128: bits per vector register; must equal the global `VLEN`; multiple of 32.
- `SYS_clk`  in  1  clock; all state updates on the rising edge.
- `SYS_reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  instruction valid; sampled only in IDLE.
- `op`  in  3  000 add, 001 sub (vs2−vs1), 010 and, 011 or, 100 xor, 101 mv (vs1); 110/111 illegal.
- `vd`, `vs1`, `vs2`  in  5 each  register indices.
- `vm`  in  1  1 = unmasked, 0 = masked by `v0`.
- `flush`  in  1  abort the current instruction (trap/interrupt).
- `v_regs`  in  VLEN*32  register file contents; register r occupies bits `[r*VLEN +: VLEN]`.
- `vl`, `vstart`  in  32 each; `vsew`, `vlmul`  in  3 each; `vill`  in  1  current CSR state.
- `busy`  out  1  high in RUN and WRITE.
- `done`  out  1  one-cycle completion pulse.
- `illegal`  out  1  one-cycle pulse with `done` on rejection.
- `aborted`  out  1  one-cycle pulse with `done` on flush.
- `wr_en`  out  1  one-cycle register write strobe.
- `wr_addr`  out  5  destination index.
- `wr_data`  out  VLEN  full destination value.
- `vstart_out`  out  32  `vstart` to commit; valid when `done`.

## Operation
- States: IDLE, RUN, WRITE.
- Reset values: state IDLE; all outputs 0; internal buffers 0.
- Acceptance:
  - IDLE + `start` latches op, indices, `vm`, SEW, and copies of vs1, vs2, vd and v0.
  - It sets `end = min(vl, VLEN/SEW)` and `idx = vstart`.
- Illegal condition: `vill`=1, `vsew`>2, `vlmul`≠0, or op 110/111. The block stays in IDLE and next cycle pulses `done`+`illegal`; `wr_en`=0 and `vstart_out`=`vstart`.
- `vstart >= end`: next cycle `done`=1, `wr_en`=0, `vstart_out`=0. No element is modified.
- Otherwise go to RUN. Each cycle processes element `idx`:
  - Element bits are `[idx*SEW +: SEW]`.
  - The result is truncated modulo 2^SEW (wrap, no saturation).
  - The result is written into the vd buffer.
  - `idx` increments.
  - When the processed `idx == end-1`, go to WRITE.
- Elements outside `[vstart, end)` keep their original vd value (tail/prestart undisturbed).
- WRITE, one cycle: `wr_en`=1, `wr_addr`=vd, `wr_data`=buffer, `vstart_out`=0, `done`=1, then IDLE.
- Flush:
  - In RUN, flush takes priority over element processing.
  - Next cycle: `wr_en`=1 with the partial buffer, `vstart_out`=index of the first unprocessed element, `done`=`aborted`=1, then IDLE.
  - Flush in WRITE is ignored; the write completes.
  - Flush in IDLE is ignored.
- `start` while busy is ignored; it is not queued.
- vd equal to vs1/vs2 is safe because sources are snapshotted at acceptance.
- Asserting `SYS_reset_n` low mid-operation clears everything immediately; no write is issued.

## Timing
- Accept at edge 0. Element k (relative to vstart) at edge k+1. WRITE/`done` visible after edge N+1, where N = `end − vstart`.
- Total latency is N+1 cycles. Back-to-back: the next `start` is accepted the cycle after `done`.
- All outputs are registered.

## Configuration
- `VEC_MASK_EN` defined: with `vm`=0, element i is processed only if `v0[i]`=1; masked-off elements keep the old vd value (mask-undisturbed) but still consume a cycle.
- Not defined: `vm` is ignored, all elements are active, and no v0 snapshot is kept.

## Structure
- `vec_pkg`: op encodings, SEW codes, state enum, and `VLMAX(sew)` helper.
- Sub-module `vec_elem_alu`: combinational 32-bit op with SEW truncation. The sequencer holds the FSM, buffers and indexing.

## Test plan
- VLEN=128, SEW=32, vl=4, vstart=0, add with vs1 all 1, vs2 = {0xFFFFFFFF,2,3,4} → `done` 5 cycles after start; `wr_data` = {0,3,4,5}; `vstart_out`=0.
- SEW=8, vl=20 (clamped to 16), sub → 16 elements written; wraparound checked at 0x00−0x01=0xFF.
- vstart=2, vl=3, xor → only element 2 changes; `done` after 2 cycles.
- Flush on the 3rd RUN cycle with vstart=0, vl=8 → partial write, `vstart_out`=2, `aborted`=1. Restart → final result matches an unflushed run.
- `vill`=1 or `vlmul`=001 → `done`+`illegal` after 1 cycle, `wr_en`=0.
- `VEC_MASK_EN`, `vm`=0, v0=0b0101 → elements 0 and 2 updated, 1 and 3 unchanged. Also assert reset mid-RUN → outputs 0 with no write.
